// File: rtl/core_scheduler_if.sv
// Bus between the per-core scheduler and the units around it: control inputs
// (start, fetch/decode/lsu status, per-thread next PC) and the scheduler outputs.
interface core_scheduler_if #(
    parameter int unsigned THREADS_PER_BLOCK     = 4,
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8
);
    logic                                               start;
    logic [2:0]                                         thread_count;
    logic                                               decoded_ret;
    logic [2:0]                                         fetcher_state;
    logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state;
    logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc;
    logic [2:0]                                         core_state;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc;
    logic                                               done;
    logic                                               diverge_err;
    logic                                               timeout_err;

    // Environment side: drives control/status, observes the scheduler.
    modport master (
        output start, thread_count, decoded_ret, fetcher_state, lsu_state, next_pc,
        input  core_state, current_pc, done, diverge_err, timeout_err
    );

    // Scheduler side.
    modport slave (
        input  start, thread_count, decoded_ret, fetcher_state, lsu_state, next_pc,
        output core_state, current_pc, done, diverge_err, timeout_err
    );
endinterface

// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences FETCH..UPDATE per instruction, owns current_pc,
// and flags thread PC divergence and LSU wait timeouts.
module core_scheduler #(
    parameter int unsigned THREADS_PER_BLOCK     = 4,
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned WAIT_TIMEOUT          = 255
) (
    input logic             clk,
    input logic             reset,
    core_scheduler_if.slave bus
);
    localparam int unsigned T     = THREADS_PER_BLOCK;
    localparam int unsigned A     = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_e;

    state_e           state_q, state_d;
    logic [A-1:0]     pc_q, pc_d;
    logic             done_q, done_d;
    logic             div_q, div_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]       count_q, count_d;

    logic             busy;
    logic             diverge;

    // Any active thread still has a memory request in flight.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(T); i++) begin
            if (i < int'(count_q) &&
                (bus.lsu_state[2*i +: 2] == LSU_REQUESTING ||
                 bus.lsu_state[2*i +: 2] == LSU_WAITING)) begin
                busy = 1'b1;
            end
        end
    end

    // Any active thread other than thread 0 reports a different next PC.
    always_comb begin
        diverge = 1'b0;
        for (int j = 1; j < int'(T); j++) begin
            if (j < int'(count_q) && bus.next_pc[j*A +: A] != bus.next_pc[A-1:0]) begin
                diverge = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        done_d     = done_q;
        div_d      = div_q;
        to_d       = to_q;
        wait_cnt_d = wait_cnt_q;
        count_d    = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    count_d = bus.thread_count;
                    if (bus.thread_count == 3'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (bus.fetcher_state == FETCHER_FETCHED) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_REQUEST;
            S_REQUEST: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (!busy) begin
                    state_d = S_EXECUTE;
                end else if (wait_cnt_q == CNT_W'(WAIT_TIMEOUT)) begin
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                if (bus.decoded_ret) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pc_d    = bus.next_pc[A-1:0];
                    state_d = S_FETCH;
                    if (diverge) div_d = 1'b1;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            done_q     <= 1'b0;
            div_q      <= 1'b0;
            to_q       <= 1'b0;
            wait_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
            div_q      <= div_d;
            to_q       <= to_d;
            wait_cnt_q <= wait_cnt_d;
            count_q    <= count_d;
        end
    end

    assign bus.core_state  = state_q;
    assign bus.current_pc  = pc_q;
    assign bus.done        = done_q;
    assign bus.diverge_err = div_q;
    assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: spec-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_core_scheduler;
    localparam int unsigned T  = 4;
    localparam int unsigned A  = 8;
    localparam int unsigned TO = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_REQUEST = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_EXECUTE = 3'd5;
    localparam logic [2:0] ST_UPDATE  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    core_scheduler_if #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) bus ();

    core_scheduler #(
        .THREADS_PER_BLOCK(T),
        .PROGRAM_MEM_ADDR_BITS(A),
        .WAIT_TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase names as plain integers, WAIT tracked by cycles spent.
    typedef struct {
        int        st;
        int        cnt;
        int        dwell;
        logic [7:0] pc;
        bit        done;
        bit        div;
        bit        to;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.st = 0; m.cnt = 0; m.dwell = 0; m.pc = 8'h00;
        m.done = 1'b0; m.div = 1'b0; m.to = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, logic start, logic [2:0] tcount,
                                          logic ret, logic [2:0] fstate,
                                          logic [2*T-1:0] lsu, logic [T*A-1:0] npc);
        model_t r = m;
        bit busy = 1'b0;
        for (int i = 0; i < int'(T); i++)
            if (i < m.cnt && (lsu[2*i +: 2] == 2'b01 || lsu[2*i +: 2] == 2'b10)) busy = 1'b1;
        case (m.st)
            0: if (start) begin
                r.cnt = int'(tcount);
                if (r.cnt == 0) begin r.st = 7; r.done = 1'b1; end
                else r.st = 1;
            end
            1: if (fstate == 3'b010) r.st = 2;
            2: r.st = 3;
            3: begin r.st = 4; r.dwell = 0; end
            4: begin
                r.dwell = m.dwell + 1;
                if (!busy) r.st = 5;
                else if (r.dwell > int'(TO)) begin r.to = 1'b1; r.done = 1'b1; r.st = 7; end
            end
            5: r.st = 6;
            6: if (ret) begin
                r.done = 1'b1; r.st = 7;
            end else begin
                for (int j = 1; j < int'(T); j++)
                    if (j < m.cnt && npc[j*A +: A] != npc[A-1:0]) r.div = 1'b1;
                r.pc = npc[A-1:0];
                r.st = 1;
            end
            default: ;
        endcase
        return r;
    endfunction

    model_t m = model_reset();

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else m <= model_step(m, bus.start, bus.thread_count, bus.decoded_ret,
                             bus.fetcher_state, bus.lsu_state, bus.next_pc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_state", 32'(bus.core_state), 32'(m.st));
        check("model_pc", 32'(bus.current_pc), 32'(m.pc));
        check("model_done", 32'(bus.done), 32'(m.done));
        check("model_div", 32'(bus.diverge_err), 32'(m.div));
        check("model_to", 32'(bus.timeout_err), 32'(m.to));
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.core_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 32'(bus.core_state), 32'(s));
    endtask

    int exp2[8] = '{1, 1, 2, 3, 4, 5, 6, 1};
    int dwell;

    initial begin
        bus.start = 1'b0; bus.thread_count = 3'd0; bus.decoded_ret = 1'b0;
        bus.fetcher_state = 3'b000; bus.lsu_state = '0; bus.next_pc = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(bus.core_state), 32'(ST_IDLE));
        check("rst_pc", 32'(bus.current_pc), 32'h0);
        check("rst_flags", {29'd0, bus.done, bus.diverge_err, bus.timeout_err}, 32'h0);
        reset = 1'b0;

        // Two-cycle fetch, no memory, all threads agree on 0x0B.
        @(negedge clk);
        bus.start = 1'b1; bus.thread_count = 3'd4; bus.next_pc = {4{8'h0B}};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("seq_state", 32'(bus.core_state), 32'(exp2[k]));
            bus.fetcher_state = (k == 1) ? 3'b010 : 3'b000;
        end
        check("seq_pc", 32'(bus.current_pc), 32'h0B);

        // Thread 1 busy for three WAIT cycles then DONE: four-cycle dwell.
        bus.fetcher_state = 3'b010;
        wait_state(ST_REQUEST, 10);
        bus.lsu_state = 8'b00_00_01_00;
        dwell = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.core_state != ST_WAIT) break;
            dwell++;
            if (dwell == 4) bus.lsu_state = 8'b00_00_11_00;
        end
        check("busy_dwell", 32'(dwell), 32'd4);
        check("busy_exec", 32'(bus.core_state), 32'(ST_EXECUTE));
        check("busy_noerr", {30'd0, bus.diverge_err, bus.timeout_err}, 32'h0);
        bus.lsu_state = '0;

        // Async reset in the middle of a stalled WAIT.
        wait_state(ST_UPDATE, 10);
        bus.lsu_state = 8'b00_00_00_10;
        wait_state(ST_WAIT, 10);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_state", 32'(bus.core_state), 32'(ST_IDLE));
        check("arst_pc", 32'(bus.current_pc), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.lsu_state = '0;
        @(negedge clk);
        check("arst_flags", {29'd0, bus.done, bus.diverge_err, bus.timeout_err}, 32'h0);

        // Two active threads; inactive threads disagree and are busy, ignored.
        bus.start = 1'b1; bus.thread_count = 3'd2;
        bus.next_pc = {8'h33, 8'h33, 8'h10, 8'h10};
        bus.lsu_state = 8'b01_00_00_00;
        @(negedge clk);
        bus.start = 1'b0;
        bus.thread_count = 3'd4;
        wait_state(ST_WAIT, 10);
        @(negedge clk);
        check("inact_dwell", 32'(bus.core_state), 32'(ST_EXECUTE));
        wait_state(ST_FETCH, 10);
        check("agree_pc", 32'(bus.current_pc), 32'h10);
        check("agree_div", 32'(bus.diverge_err), 32'h0);
        bus.next_pc = {8'h33, 8'h33, 8'h11, 8'h10};
        wait_state(ST_UPDATE, 10);
        @(negedge clk);
        check("div_state", 32'(bus.core_state), 32'(ST_FETCH));
        check("div_pc", 32'(bus.current_pc), 32'h10);
        check("div_flag", 32'(bus.diverge_err), 32'h1);

        // Thread 0 stuck WAITING: timeout after TO+1 WAIT cycles.
        bus.lsu_state = 8'b01_00_00_10;
        wait_state(ST_WAIT, 10);
        dwell = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.core_state != ST_WAIT) break;
            dwell++;
        end
        check("to_dwell", 32'(dwell), 32'd5);
        check("to_state", 32'(bus.core_state), 32'(ST_DONE));
        check("to_flags", {29'd0, bus.done, bus.diverge_err, bus.timeout_err}, 32'h7);

        // RET ends the block; start afterwards is ignored.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.lsu_state = '0; bus.decoded_ret = 1'b1; bus.next_pc = {4{8'h22}};
        bus.start = 1'b1; bus.thread_count = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        wait_state(ST_DONE, 20);
        check("ret_done", 32'(bus.done), 32'h1);
        check("ret_pc", 32'(bus.current_pc), 32'h0);
        for (int k = 0; k < 4; k++) begin
            bus.start = ~bus.start;
            @(negedge clk);
            check("ret_hold", 32'(bus.core_state), 32'(ST_DONE));
        end
        bus.start = 1'b0;

        // Zero threads: straight from IDLE to DONE.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.decoded_ret = 1'b0;
        bus.start = 1'b1; bus.thread_count = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_state", 32'(bus.core_state), 32'(ST_DONE));
        check("zero_done", 32'(bus.done), 32'h1);
        check("zero_pc", 32'(bus.current_pc), 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
